// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Holds one response across stalls and drains an open request after a redirect.
module fetch_stage #(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallf,
    input  logic            stalld,
    input  logic            flushd,
    input  logic            pcsrce,
    input  logic [XLEN-1:0] pctargete,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pcf,
    output logic [31:0]     instrd,
    output logic [XLEN-1:0] pcd,
    output logic [XLEN-1:0] pcplus4d,
    output logic            validd
);

    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [ILEN-1:0] buf_q, buf_d;
    logic [ILEN-1:0] instrd_q, instrd_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcplus4d_q, pcplus4d_d;
    logic            validd_q, validd_d;

    logic            avail;
    logic [ILEN-1:0] instr_src;
    logic [XLEN-1:0] pcf_plus4;

    assign avail     = ((state_q == S_FETCH) && imem_ready) || (state_q == S_HOLD);
    assign instr_src = (state_q == S_HOLD) ? buf_q : imem_rdata;
    assign pcf_plus4 = pcf_q + XLEN'(4);

    // IF/ID register update: flush beats stall beats load
    always_comb begin
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        validd_d   = validd_q;
        if (flushd) begin
            instrd_d   = NOP_INSTR;
            pcd_d      = '0;
            pcplus4d_d = '0;
            validd_d   = 1'b0;
        end else if (!stalld) begin
            if (avail && !pcsrce) begin
                instrd_d   = instr_src;
                pcd_d      = pcf_q;
                pcplus4d_d = pcf_plus4;
                validd_d   = 1'b1;
            end else begin
                instrd_d   = NOP_INSTR;
                pcd_d      = '0;
                pcplus4d_d = '0;
                validd_d   = 1'b0;
            end
        end
    end

    // PC and fetch-state sequencing; a redirect always outranks stallf
    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        redir_d = redir_q;
        buf_d   = buf_q;
        if (pcsrce) begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        pcf_d = pctargete;
                    end else begin
                        redir_d = pctargete;
                        state_d = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    pcf_d   = pctargete;
                    state_d = S_FETCH;
                end
                default: redir_d = pctargete;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        if (stallf) begin
                            buf_d   = imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            pcf_d = pcf_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stallf) begin
                        pcf_d   = pcf_plus4;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    if (imem_ready) begin
                        pcf_d   = redir_q;
                        state_d = S_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pcf_q      <= RESET_PC;
            redir_q    <= '0;
            buf_q      <= '0;
            instrd_q   <= NOP_INSTR;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            validd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            redir_q    <= redir_d;
            buf_q      <= buf_d;
            instrd_q   <= instrd_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            validd_q   <= validd_d;
        end
    end

    assign imem_req  = (state_q != S_HOLD);
    assign imem_addr = pcf_q;
    assign pcf       = pcf_q;
    assign instrd    = instrd_q;
    assign pcd       = pcd_q;
    assign pcplus4d  = pcplus4d_q;
    assign validd    = validd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-drain sequence,
// and randomized traffic checked against a transaction-level fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallf, stalld, flushd, pcsrce;
    logic [31:0] pctargete;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pcf, instrd, pcd, pcplus4d;
    logic        validd;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stallf(stallf), .stalld(stalld), .flushd(flushd),
        .pcsrce(pcsrce), .pctargete(pctargete), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pcf(pcf), .instrd(instrd),
        .pcd(pcd), .pcplus4d(pcplus4d), .validd(validd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch PC, an optional parked instruction, an optional pending redirect
    logic [31:0] m_pc, m_hbuf, m_redir, m_instrd, m_pcd, m_pcp4;
    logic        m_held, m_pending, m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_held = 1'b0; m_pending = 1'b0; m_hbuf = '0; m_redir = '0;
        m_instrd = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic br,
                              input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
        logic        got;
        logic [31:0] word;
        got  = m_held || (!m_pending && rdy);
        word = m_held ? m_hbuf : rd;
        if (fl || (!st && !(got && !br))) begin
            m_instrd = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 1'b0;
        end else if (!st) begin
            m_instrd = word; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        if (br) begin
            if (m_held) begin
                m_held = 1'b0; m_pc = tgt;
            end else if (m_pending || !rdy) begin
                m_pending = 1'b1; m_redir = tgt;
            end else begin
                m_pc = tgt;
            end
        end else if (m_pending) begin
            if (rdy) begin
                m_pending = 1'b0; m_pc = m_redir;
            end
        end else if (m_held) begin
            if (!st) begin
                m_held = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else if (rdy) begin
            if (st) begin
                m_held = 1'b1; m_hbuf = rd;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input logic st, input logic fl, input logic br,
                         input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        stallf = st; stalld = st; flushd = fl; pcsrce = br; pctargete = tgt;
        imem_ready = rdy;
        imem_rdata = rdy ? mem_word(m_pc) : $urandom;
        #1;
        chk("imem_req", 32'(imem_req), 32'(!m_held));
        chk("imem_addr", imem_addr, m_pc);
        model_step(st, fl, br, tgt, rdy, imem_rdata);
        @(posedge clk);
        #1;
        chk("pcf", pcf, m_pc);
        chk("instrd", instrd, m_instrd);
        chk("pcd", pcd, m_pcd);
        chk("pcplus4d", pcplus4d, m_pcp4);
        chk("validd", 32'(validd), 32'(m_valid));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stallf = 0; stalld = 0; flushd = 0; pcsrce = 0;
        pctargete = '0; imem_ready = 0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        st, fl, br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] e_pcf, e_pcd;
        logic        e_val, e_req;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic st, input logic fl, input logic br,
                                input logic [31:0] tgt, input logic rdy,
                                input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                                input logic e_val, input logic e_req);
        vec_t v;
        v.st = st; v.fl = fl; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.e_pcf = e_pcf; v.e_pcd = e_pcd; v.e_val = e_val; v.e_req = e_req;
        return v;
    endfunction

    initial begin
        // sequential zero-wait fetch
        tbl[0]  = mk(0,0,0,32'h0,1, 32'h04, 32'h00, 1, 1);
        tbl[1]  = mk(0,0,0,32'h0,1, 32'h08, 32'h04, 1, 1);
        tbl[2]  = mk(0,0,0,32'h0,1, 32'h0C, 32'h08, 1, 1);
        tbl[3]  = mk(0,0,0,32'h0,1, 32'h10, 32'h0C, 1, 1);
        // stall on the response at 0x10, then release
        tbl[4]  = mk(1,0,0,32'h0,1, 32'h10, 32'h0C, 1, 0);
        tbl[5]  = mk(1,0,0,32'h0,0, 32'h10, 32'h0C, 1, 0);
        tbl[6]  = mk(0,0,0,32'h0,0, 32'h14, 32'h10, 1, 1);
        // ready every third cycle
        tbl[7]  = mk(0,0,0,32'h0,0, 32'h14, 32'h00, 0, 1);
        tbl[8]  = mk(0,0,0,32'h0,0, 32'h14, 32'h00, 0, 1);
        tbl[9]  = mk(0,0,0,32'h0,1, 32'h18, 32'h14, 1, 1);
        tbl[10] = mk(0,0,0,32'h0,1, 32'h1C, 32'h18, 1, 1);
        tbl[11] = mk(0,0,0,32'h0,1, 32'h20, 32'h1C, 1, 1);
        // redirect while 0x20 is outstanding
        tbl[12] = mk(0,0,1,32'h100,0, 32'h20, 32'h00, 0, 1);
        tbl[13] = mk(0,0,0,32'h0,1,   32'h100, 32'h00, 0, 1);
        tbl[14] = mk(0,0,0,32'h0,1,   32'h104, 32'h100, 1, 1);
        // two redirects in drain: the later one wins
        tbl[15] = mk(0,0,1,32'h40,0, 32'h104, 32'h00, 0, 1);
        tbl[16] = mk(0,0,1,32'h80,0, 32'h104, 32'h00, 0, 1);
        tbl[17] = mk(0,0,0,32'h0,1,  32'h80, 32'h00, 0, 1);
        tbl[18] = mk(0,0,0,32'h0,1,  32'h84, 32'h80, 1, 1);
        // flush together with stall
        tbl[19] = mk(1,1,0,32'h0,1, 32'h84, 32'h00, 0, 0);
        tbl[20] = mk(0,0,0,32'h0,0, 32'h88, 32'h84, 1, 1);
        // redirect to the top of the address space, then wrap
        tbl[21] = mk(0,0,1,32'hFFFF_FFFC,1, 32'hFFFF_FFFC, 32'h00, 0, 1);
        tbl[22] = mk(0,0,0,32'h0,1, 32'h00, 32'hFFFF_FFFC, 1, 1);
        // redirect while holding
        tbl[23] = mk(1,0,0,32'h0,1,   32'h00, 32'hFFFF_FFFC, 1, 0);
        tbl[24] = mk(1,0,1,32'h200,0, 32'h200, 32'hFFFF_FFFC, 1, 1);
        tbl[25] = mk(0,0,0,32'h0,1,   32'h204, 32'h200, 1, 1);

        reset = 1'b1; stallf = 0; stalld = 0; flushd = 0; pcsrce = 0;
        pctargete = '0; imem_ready = 0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pcf", pcf, 32'h0);
        chk("rst_instrd", instrd, NOP);
        chk("rst_pcd", pcd, 32'h0);
        chk("rst_pcplus4d", pcplus4d, 32'h0);
        chk("rst_validd", 32'(validd), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h1);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
            chk($sformatf("vec%0d_pcf", i), pcf, tbl[i].e_pcf);
            chk($sformatf("vec%0d_pcd", i), pcd, tbl[i].e_pcd);
            chk($sformatf("vec%0d_validd", i), 32'(validd), 32'(tbl[i].e_val));
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("vec%0d_instrd", i), instrd,
                tbl[i].e_val ? mem_word(tbl[i].e_pcd) : NOP);
            chk($sformatf("vec%0d_pcplus4d", i), pcplus4d,
                tbl[i].e_val ? tbl[i].e_pcd + 32'd4 : 32'h0);
        end

        // reset asserted in the middle of a drain takes effect immediately
        cycle(0,0,1,32'h300,0);
        @(negedge clk);
        pcsrce = 0; imem_ready = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pcf", pcf, 32'h0);
        chk("mid_rst_validd", 32'(validd), 32'h0);
        chk("mid_rst_instrd", instrd, NOP);
        chk("mid_rst_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(0,0,0,32'h0,1);
        chk("post_rst_pcf", pcf, 32'h4);
        chk("post_rst_pcd", pcd, 32'h0);
        chk("post_rst_validd", 32'(validd), 32'h1);

        // ready every third cycle
        do_reset();
        for (int i = 0; i < 60; i++)
            cycle(0, 0, 0, 32'h0, (i % 3) == 2);

        // random hazards, redirects and wait states
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic st, fl, br, rdy;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cycle(st, fl, br, tgt, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
